// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/ack bus between the fetch stage (master) and memory (slave).
interface fetch_pc_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch/PC stage: fetches the word at pc, holds it for the decoder, then resolves the next pc
// from branch/jump/jr controls. Halts permanently on a misaligned target.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             nrst,
    fetch_pc_unit_if.master  imem,
    output logic [31:0]      instr,
    output logic [5:0]       opcode,
    output logic             instr_valid,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    input  logic             exec_done,
    input  logic             branch,
    input  logic             alu_zero,
    input  logic             mux_branch_jump,
    input  logic             mux_j_type_addr_to_read,
    input  logic [31:0]      jr_target,
    output logic             addr_err,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

    state_t      state, state_nxt;
    logic [31:0] next_pc;
    logic [31:0] br_off;
    logic        taken;
    logic        misaligned;
    logic        fire_fetch;
    logic        fire_exec;

    assign opcode         = instr[31:26];
    assign pc_plus4       = pc + 32'd4;
    assign imem.imem_addr = pc;

    // instr[26] distinguishes bne from beq, so it inverts the sense of the zero flag
    assign taken  = branch & (alu_zero ^ instr[26]);
    assign br_off = {{14{instr[15]}}, instr[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (!mux_branch_jump && !mux_j_type_addr_to_read)
            next_pc = jr_target;
        else if (!mux_branch_jump)
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if (taken)
            next_pc = pc_plus4 + br_off;
    end

    assign misaligned = |next_pc[1:0];
    assign fire_fetch = (state == FETCH) && imem.imem_ack;
    assign fire_exec  = (state == HOLD) && exec_done;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = FETCH;
            FETCH:   if (imem.imem_ack) state_nxt = HOLD;
            HOLD:    if (exec_done) state_nxt = misaligned ? HALT : FETCH;
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem.imem_req = 1'b0;
        instr_valid   = 1'b0;
        case (state)
            FETCH:   imem.imem_req = 1'b1;
            HOLD:    instr_valid   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pc       <= RESET_PC;
            instr    <= 32'd0;
            addr_err <= 1'b0;
            retired  <= '0;
        end else begin
            if (fire_fetch)
                instr <= imem.imem_rdata;
            if (fire_exec) begin
                if (misaligned) begin
                    addr_err <= 1'b1;
                end else begin
                    pc      <= next_pc;
                    retired <= retired + CNT_W'(1);
                end
            end
        end
    end

endmodule
